if_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC, issues in-order reads to instruction memory, and buffers returned words.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_slot_buf.sv | 76 +++++++
 rtl/if_fetch.sv | 112 +++++++++++
 tb/tb_if_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Bus widths, slot record and PC increment helper.
package if_fetch_pkg;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned IF_DEPTH    = 2;
    localparam int unsigned DROP_W      = 4;
    localparam logic        RST_ACTIVE  = 1'b0;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_slot_t;

    function automatic inst_addr_t next_pc(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/if_slot_buf.sv
// Prefetch slot ring: slot allocated at grant, filled at response, freed at consume.
// Latency: a fill is visible on head_* the cycle after it is written.
// Backpressure: cnt_o reports allocated slots; the issuer stops at DEPTH.
module if_slot_buf
    import if_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           alloc_i,
    input  inst_addr_t     alloc_pc_i,
    input  logic           fill_i,
    input  inst_t          fill_dat_i,
    input  logic           pop_i,
    output logic [PTR_W:0] cnt_o,
    output logic [PTR_W:0] unfilled_o,
    output logic           head_vld_o,
    output inst_addr_t     head_pc_o,
    output inst_t          head_inst_o
);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one wrap bit so full and empty stay distinguishable.
    logic [PTR_W:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W:0] fill_ptr_q,  fill_ptr_d;
    logic [PTR_W:0] head_ptr_q,  head_ptr_d;
    fetch_slot_t    slot_q [DEPTH];
    fetch_slot_t    slot_d [DEPTH];

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        slot_d      = slot_q;
        if (flush_i) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
        end else begin
            if (alloc_i) begin
                slot_d[alloc_ptr_q[PTR_W-1:0]].pc = alloc_pc_i;
                alloc_ptr_d = alloc_ptr_q + PTR_ONE;
            end
            if (fill_i) begin
                slot_d[fill_ptr_q[PTR_W-1:0]].inst = fill_dat_i;
                fill_ptr_d = fill_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                head_ptr_d = head_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            slot_q      <= '{default: '0};
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            slot_q      <= slot_d;
        end
    end

    assign cnt_o       = alloc_ptr_q - head_ptr_q;
    assign unfilled_o  = alloc_ptr_q - fill_ptr_q;
    assign head_vld_o  = (fill_ptr_q != head_ptr_q);
    assign head_pc_o   = head_vld_o ? slot_q[head_ptr_q[PTR_W-1:0]].pc   : ZERO_WORD;
    assign head_inst_o = head_vld_o ? slot_q[head_ptr_q[PTR_W-1:0]].inst : ZERO_WORD;
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues in-order ROM reads, presents buffered words (IF_REDIRECT_EN adds redirect).
// Latency: ROM response -> inst_valid_o in 1 cycle; 1 instruction/cycle with a 1-cycle ROM.
// Backpressure: id_stall_i holds the head; requests pause once DEPTH reads are allocated.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = IF_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    input  logic        id_stall_i,
`ifdef IF_REDIRECT_EN
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    inst_addr_t     pc_q, pc_d;
    logic           run_q, run_d;
    logic [PTR_W:0] cnt, unfilled;
    logic           grant, fill, pop, flush;

    assign pop   = inst_valid_o & ~id_stall_i;
    assign grant = rom_req_o & rom_gnt_i;
    // cnt never exceeds DEPTH (a power of 2), so its MSB alone means "full".
    assign rom_req_o  = run_q & ~flush & (~cnt[PTR_W] | pop);
    assign rom_addr_o = pc_q;

`ifdef IF_REDIRECT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    assign flush = redirect_i;
    assign fill  = rom_rvalid_i & (drop_cnt_q == '0);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            // Everything still in flight goes stale; a response arriving now is one of them.
            drop_cnt_d = drop_cnt_q + DROP_W'(unfilled) - DROP_W'(rom_rvalid_i);
        end else if (rom_rvalid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    assign flush = 1'b0;
    assign fill  = rom_rvalid_i;
`endif

    always_comb begin
        pc_d  = pc_q;
        run_d = 1'b1;
        if (grant) begin
            pc_d = next_pc(pc_q);
        end
`ifdef IF_REDIRECT_EN
        if (flush) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end
`endif
    end

    // run_q keeps requests off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            run_q <= run_d;
        end
    end

    if_slot_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_slot_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .alloc_i     (grant),
        .alloc_pc_i  (pc_q),
        .fill_i      (fill),
        .fill_dat_i  (rom_rdata_i),
        .pop_i       (pop),
        .cnt_o       (cnt),
        .unfilled_o  (unfilled),
        .head_vld_o  (inst_valid_o),
        .head_pc_o   (pc_o),
        .head_inst_o (inst_o)
    );

    a_fill_has_slot: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
        fill |-> (unfilled != '0));
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an in-order ROM model and a stream-level reference model.
module tb_if_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_req_o, rom_gnt_i, rom_rvalid_i, id_stall_i, inst_valid_o;
    logic [31:0] rom_addr_o, rom_rdata_i, pc_o, inst_o;
    logic        w_req, w_rvalid, w_stall, w_vld;
    logic [31:0] w_addr, w_rdata, w_pc, w_inst;
`ifdef IF_REDIRECT_EN
    logic        redirect_i, w_redirect;
    logic [31:0] redirect_pc_i, w_redirect_pc;
`endif

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst(rst),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
        .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i), .id_stall_i(id_stall_i),
`ifdef IF_REDIRECT_EN
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
`endif
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .rom_req_o(w_req), .rom_addr_o(w_addr), .rom_gnt_i(rom_gnt_i),
        .rom_rvalid_i(w_rvalid), .rom_rdata_i(w_rdata), .id_stall_i(w_stall),
`ifdef IF_REDIRECT_EN
        .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
`endif
        .pc_o(w_pc), .inst_o(w_inst), .inst_valid_o(w_vld)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } rd_t;

    rd_t         romq[$];
    rd_t         wq[$];
    logic [31:0] w_seen[$];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, lat = 1;
    int          allocated = 0, delivered = 0;
    logic [31:0] exp_issue_pc = 32'h0, exp_cons_pc = 32'h0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, let outputs settle, compare against the model, advance the model.
    task automatic cycle(input bit stall, input bit gnt, input bit redir, input logic [31:0] rpc);
        bit  resp_stale, exp_valid, exp_pop, exp_req;
        rd_t r;
        @(posedge clk);
        #1;
        cyc++;
        id_stall_i = stall;
        rom_gnt_i  = gnt;
`ifdef IF_REDIRECT_EN
        redirect_i    = redir;
        redirect_pc_i = rpc;
`endif
        rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0; resp_stale = 1'b0;
        if (romq.size() > 0 && romq[0].due <= cyc) begin
            r = romq.pop_front();
            rom_rvalid_i = 1'b1; rom_rdata_i = rom_word(r.addr); resp_stale = r.stale;
        end
        w_rvalid = 1'b0; w_rdata = 32'h0;
        if (wq.size() > 0 && wq[0].due <= cyc) begin
            r = wq.pop_front();
            w_rvalid = 1'b1; w_rdata = rom_word(r.addr);
        end
        #2;
        exp_valid = (delivered > 0);
        exp_pop   = exp_valid && !stall;
        exp_req   = !redir && ((allocated < DEPTH) || exp_pop);
        check("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, exp_valid});
        check("pc_o", pc_o, exp_valid ? exp_cons_pc : 32'h0);
        check("inst_o", inst_o, exp_valid ? rom_word(exp_cons_pc) : 32'h0);
        check("rom_req_o", {31'b0, rom_req_o}, {31'b0, exp_req});
        check("rom_addr_o", rom_addr_o, exp_issue_pc);
        // The ROM answers whatever the DUT really issued.
        if (rom_req_o && gnt) romq.push_back('{rom_addr_o, cyc + lat, 1'b0});
        if (w_req && gnt) begin
            if (w_seen.size() < 3) w_seen.push_back(w_addr);
            wq.push_back('{w_addr, cyc + 1, 1'b0});
        end
        if (redir) begin
            foreach (romq[i]) romq[i].stale = 1'b1;
            allocated = 0; delivered = 0;
            exp_issue_pc = rpc; exp_cons_pc = rpc;
        end else begin
            if (rom_rvalid_i && !resp_stale) delivered++;
            if (exp_pop) begin
                delivered--; allocated--; exp_cons_pc += 32'd4;
            end
            if (exp_req && gnt) begin
                allocated++; exp_issue_pc += 32'd4;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int          first_vld, n_vld;
        logic [31:0] held_pc, held_inst, held_addr;
        bit          found;
        rst = 1'b0; rom_gnt_i = 1'b1; id_stall_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0; w_stall = 1'b0;
`ifdef IF_REDIRECT_EN
        redirect_i = 1'b0; redirect_pc_i = 32'h0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_req", {31'b0, rom_req_o}, 32'd0);
            check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
            check("rst_pc", pc_o, 32'h0);
            check("rst_inst", inst_o, 32'h0);
            check("rst_addr", rom_addr_o, 32'h0);
            check("rst_addr_wrap", w_addr, 32'hFFFF_FFF8);
        end
        rst = 1'b1;

        // Streaming with a 1-cycle ROM
        first_vld = 0; n_vld = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                check("first_req", {31'b0, rom_req_o}, 32'd1);
                check("first_addr", rom_addr_o, 32'h0);
            end
            if (inst_valid_o) begin
                n_vld++;
                if (first_vld == 0) first_vld = cyc;
            end
            if (cyc == 3) begin
                check("pc_c3", pc_o, 32'h0);
                check("inst_c3", inst_o, 32'h1000);
            end
            if (cyc == 4) check("inst_c4", inst_o, 32'h1004);
        end
        check("first_valid_cycle", first_vld, 32'd3);
        check("valid_cycles", n_vld, 32'd10);
        check("wrap_issue_count", w_seen.size(), 32'd3);
        if (w_seen.size() == 3) begin
            check("wrap_addr0", w_seen[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_seen[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_seen[2], 32'h0000_0000);
        end

        // Decode stall for 5 cycles
        held_pc = 32'h0; held_inst = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                held_pc = pc_o; held_inst = inst_o;
            end else begin
                check("stall_hold_pc", pc_o, held_pc);
                check("stall_hold_inst", inst_o, held_inst);
            end
        end
        check("stall_req_drop", {31'b0, rom_req_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) check("resume_pc0", pc_o, held_pc);
            if (i == 1) check("resume_pc1", pc_o, held_pc + 32'd4);
        end

        // Grant withheld for 3 cycles
        held_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 0) held_addr = rom_addr_o;
            check("nognt_req", {31'b0, rom_req_o}, 32'd1);
            check("nognt_addr", rom_addr_o, held_addr);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("gnt_advance", rom_addr_o, held_addr + 32'd4);

        // Mixed stall / grant pattern with a 2-cycle ROM
        lat = 2;
        for (int i = 0; i < 16; i++) cycle(i % 3 == 1, i % 4 != 2, 1'b0, 32'h0);

`ifdef IF_REDIRECT_EN
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        check("redir_req_low", {31'b0, rom_req_o}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 0) check("redir_valid_low", {31'b0, inst_valid_o}, 32'd0);
            if (inst_valid_o) begin
                found = 1'b1;
                check("redir_first_pc", pc_o, 32'h100);
                check("redir_first_inst", inst_o, 32'h1100);
            end
        end
        if (!found) check("redir_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
`else
        found = 1'b0;
`endif
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
